reaction_measure: RTL and testbench

Reaction-time measurement controller for the reaction timer system.
- Issues a one-cycle start pulse to the random delay generator, then waits for its delay-complete flag.
- On delay-complete, lights the stimulus LED and counts elapsed milliseconds until the user presses stop.
- Reports a valid time, an early (cheat) press, or a timeout to the display logic.

---
 rtl/reaction_measure.sv | 116 +++++++++++
 tb/tb_reaction_measure.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_measure.sv
// Reaction-time controller: starts the random delay, lights the stimulus LED,
// then counts elapsed milliseconds until stop, reporting done, early or timeout.
module reaction_measure #(
    parameter int TICKS_PER_MS = 100000,
    parameter int MAX_MS       = 1000,
    parameter int MS_WIDTH     = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                delay_complete,
    output logic                delay_start,
    output logic                stimulus,
    output logic [MS_WIDTH-1:0] reaction_ms,
    output logic                done,
    output logic                early,
    output logic                timeout
);

    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0] MS_MAX      = MS_WIDTH'(MAX_MS);
    localparam logic [MS_WIDTH-1:0] MS_PRE_MAX  = MS_WIDTH'(MAX_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DELAY,
        MEASURE,
        DONE,
        EARLY,
        TIMEOUT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_next;
    logic [MS_WIDTH-1:0] ms_next;
    logic                delay_start_next;

    always_comb begin
        state_next       = state;
        tick_next        = tick_cnt;
        ms_next          = reaction_ms;
        delay_start_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next       = WAIT_DELAY;
                    delay_start_next = 1'b1;
                    ms_next          = '0;
                end
            end
            WAIT_DELAY: begin
                // A press before the stimulus is a cheat even if the delay ends this cycle
                if (stop) begin
                    state_next = EARLY;
                end else if (delay_complete) begin
                    state_next = MEASURE;
                    tick_next  = '0;
                    ms_next    = '0;
                end
            end
            MEASURE: begin
                // Stop freezes the count, discarding any increment due this cycle
                if (stop) begin
                    state_next = DONE;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    if (reaction_ms == MS_PRE_MAX) begin
                        ms_next    = MS_MAX;
                        state_next = TIMEOUT;
                    end else begin
                        ms_next = reaction_ms + 1'b1;
                    end
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            DONE, EARLY, TIMEOUT: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flags are registered from the next state so each one tracks its state exactly
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            reaction_ms <= '0;
            delay_start <= 1'b0;
            stimulus    <= 1'b0;
            done        <= 1'b0;
            early       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            tick_cnt    <= tick_next;
            reaction_ms <= ms_next;
            delay_start <= delay_start_next;
            stimulus    <= (state_next == MEASURE);
            done        <= (state_next == DONE);
            early       <= (state_next == EARLY);
            timeout     <= (state_next == TIMEOUT);
        end
    end

endmodule

// File: tb/tb_reaction_measure.sv
// Directed bench for reaction_measure with small timing parameters so
// millisecond counts and the timeout are reached in a few hundred cycles.
module tb_reaction_measure;

    localparam int TICKS_PER_MS = 10;
    localparam int MAX_MS       = 20;
    localparam int MS_WIDTH     = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                clear = 1'b0;
    logic                delay_complete = 1'b0;
    logic                delay_start;
    logic                stimulus;
    logic [MS_WIDTH-1:0] reaction_ms;
    logic                done;
    logic                early;
    logic                timeout;

    int checks = 0;
    int failures = 0;
    int ds_count = 0;
    int stim_count = 0;
    int ds_base;
    int stim_base;

    reaction_measure #(
        .TICKS_PER_MS(TICKS_PER_MS),
        .MAX_MS(MAX_MS),
        .MS_WIDTH(MS_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .clear(clear),
        .delay_complete(delay_complete),
        .delay_start(delay_start),
        .stimulus(stimulus),
        .reaction_ms(reaction_ms),
        .done(done),
        .early(early),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Cycle counters for pulse widths, sampled mid-cycle
    always @(negedge clk) begin
        if (delay_start) ds_count = ds_count + 1;
        if (stimulus) stim_count = stim_count + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Flag vector order: {delay_start, stimulus, done, early, timeout}
    task automatic test_reset();
        reset = 1'b0;
        step(2);
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00000 || reaction_ms !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: flags=%b ms=%0d required flags=00000 ms=0",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_normal_run();
        ds_base = ds_count;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL normal_delay_start: flags=%b required 10000",
                     {delay_start, stimulus, done, early, timeout});
        end
        step(49);
        delay_complete = 1'b1;
        step(1);
        delay_complete = 1'b0;
        stim_base = stim_count;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b01000 || reaction_ms !== 5'd0) begin
            failures++;
            $display("[TB] FAIL normal_stimulus_on: flags=%b ms=%0d required flags=01000 ms=0",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        step(72);
        checks++;
        if (reaction_ms !== 5'd7 || stimulus !== 1'b1) begin
            failures++;
            $display("[TB] FAIL normal_pre_stop: ms=%0d stim=%b required ms=7 stim=1",
                     reaction_ms, stimulus);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00100 || reaction_ms !== 5'd7) begin
            failures++;
            $display("[TB] FAIL normal_done: flags=%b ms=%0d required flags=00100 ms=7",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        checks++;
        if (stim_count - stim_base !== 73 || ds_count - ds_base !== 1) begin
            failures++;
            $display("[TB] FAIL normal_pulse_widths: stim_cycles=%0d ds_cycles=%0d required 73 and 1",
                     stim_count - stim_base, ds_count - ds_base);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00000 || reaction_ms !== 5'd7) begin
            failures++;
            $display("[TB] FAIL normal_clear: flags=%b ms=%0d required flags=00000 ms=7",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
    endtask

    task automatic test_early_press();
        stim_base = stim_count;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00010 || reaction_ms !== 5'd0
            || stim_count - stim_base !== 0) begin
            failures++;
            $display("[TB] FAIL early_press: flags=%b ms=%0d stim_cycles=%0d required flags=00010 ms=0 stim_cycles=0",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms, stim_count - stim_base);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_clear: early=%b required 0", early);
        end
    endtask

    task automatic test_tie_break();
        stim_base = stim_count;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        stop = 1'b1;
        delay_complete = 1'b1;
        step(1);
        stop = 1'b0;
        delay_complete = 1'b0;
        step(2);
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00010 || stim_count - stim_base !== 0) begin
            failures++;
            $display("[TB] FAIL tie_break: flags=%b stim_cycles=%0d required flags=00010 stim_cycles=0",
                     {delay_start, stimulus, done, early, timeout}, stim_count - stim_base);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_timeout();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        delay_complete = 1'b1;
        step(1);
        delay_complete = 1'b0;
        stim_base = stim_count;
        step(199);
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b01000 || reaction_ms !== 5'd19) begin
            failures++;
            $display("[TB] FAIL timeout_pre: flags=%b ms=%0d required flags=01000 ms=19",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        step(1);
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00001 || reaction_ms !== 5'd20
            || stim_count - stim_base !== 200) begin
            failures++;
            $display("[TB] FAIL timeout_hit: flags=%b ms=%0d stim_cycles=%0d required flags=00001 ms=20 stim_cycles=200",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms, stim_count - stim_base);
        end
        stop = 1'b1;
        step(3);
        stop = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00001 || reaction_ms !== 5'd20) begin
            failures++;
            $display("[TB] FAIL timeout_late_stop: flags=%b ms=%0d required flags=00001 ms=20",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset_mid_measure();
        start = 1'b1;
        step(1);
        start = 1'b0;
        delay_complete = 1'b1;
        step(1);
        delay_complete = 1'b0;
        step(45);
        checks++;
        if (reaction_ms !== 5'd4 || stimulus !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_pre: ms=%0d stim=%b required ms=4 stim=1", reaction_ms, stimulus);
        end
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00000 || reaction_ms !== 5'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: flags=%b ms=%0d required flags=00000 ms=0",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (delay_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_restart: delay_start=%b required 1", delay_start);
        end
        delay_complete = 1'b1;
        step(1);
        delay_complete = 1'b0;
        step(14);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00100 || reaction_ms !== 5'd1) begin
            failures++;
            $display("[TB] FAIL midreset_rerun: flags=%b ms=%0d required flags=00100 ms=1",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        ds_base = ds_count;
        start = 1'b1;
        step(1);
        start = 1'b0;
        delay_complete = 1'b1;
        step(1);
        delay_complete = 1'b0;
        step(10);
        start = 1'b1;
        step(5);
        start = 1'b0;
        checks++;
        if (reaction_ms !== 5'd1 || stimulus !== 1'b1 || ds_count - ds_base !== 1) begin
            failures++;
            $display("[TB] FAIL ignore_start_measure: ms=%0d stim=%b ds_cycles=%0d required ms=1 stim=1 ds_cycles=1",
                     reaction_ms, stimulus, ds_count - ds_base);
        end
        stop = 1'b1;
        step(1);
        start = 1'b1;
        step(3);
        start = 1'b0;
        stop = 1'b0;
        step(1);
        checks++;
        if ({delay_start, stimulus, done, early, timeout} !== 5'b00100 || reaction_ms !== 5'd1
            || ds_count - ds_base !== 1) begin
            failures++;
            $display("[TB] FAIL ignore_in_done: flags=%b ms=%0d ds_cycles=%0d required flags=00100 ms=1 ds_cycles=1",
                     {delay_start, stimulus, done, early, timeout}, reaction_ms, ds_count - ds_base);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_early_press();
        test_tie_break();
        test_timeout();
        test_reset_mid_measure();
        test_ignored_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
